// File: rtl/fdc_pkg.sv
// Shared definitions for the FDC decimator / UART framer: TX state encoding,
// default sync byte and accumulator width.
package fdc_pkg;

    localparam int         ACC_W         = 15;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/fdc_uart_tx.sv
// Byte-level 8N1 serializer, LSB first, registered tx output.
// Handshake: a byte is taken on any rising edge where load_valid and load_ready are both high.
module fdc_uart_tx
    import fdc_pkg::*;
#(
    parameter int CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic       tx
);

    localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

    tx_state_e   state_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shreg_q;
    logic        tx_q;

    // Ready in the final stop-bit cycle as well, so back-to-back bytes leave no idle gap.
    assign load_ready = (state_q == TX_IDLE) || ((state_q == TX_STOP) && (cnt_q == LAST));
    assign tx         = tx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
        end else if (load_valid && load_ready) begin
            state_q <= TX_START;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= load_data;
            tx_q    <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: begin
                    tx_q <= 1'b1;
                end
                TX_START: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= TX_DATA;
                        tx_q    <= shreg_q[0];
                        shreg_q <= {1'b0, shreg_q[7:1]};
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                TX_DATA: begin
                    if (cnt_q == LAST) begin
                        cnt_q <= '0;
                        if (bit_q == 3'd7) begin
                            state_q <= TX_STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            tx_q    <= shreg_q[0];
                            shreg_q <= {1'b0, shreg_q[7:1]};
                        end
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                TX_STOP: begin
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= TX_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                    tx_q <= 1'b1;
                end
                default: begin
                    state_q <= TX_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fdc_decim_uart.sv
// FDC sample decimator: sums 2^dec_log2 codes per window and ships each sum as a
// three-byte UART frame {SYNC, sum[15:8], sum[7:0]}; windows finishing mid-frame are dropped.
module fdc_decim_uart
    import fdc_pkg::*;
#(
    parameter int         CLK_DIV   = 434,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       sample_valid,
    input  logic [7:0] sample_data,
    input  logic [2:0] dec_log2,
    input  logic       overrun_clr,
    output logic       tx,
    output logic       busy,
    output logic       overrun
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [2:0]       dec_q, dec_d;
    logic [15:0]      hold_q, hold_d;
    logic [1:0]       byte_idx_q, byte_idx_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;

    logic             accept, win_done, start_frame;
    logic [2:0]       dec_eff;
    logic [7:0]       win_len, cnt_inc;
    logic [ACC_W-1:0] sum;
    logic             load_valid, load_ready;
    logic [7:0]       load_data;

    always_comb begin
        accept      = enable && sample_valid;
        // The window length is fixed by whatever dec_log2 reads when the window opens.
        dec_eff     = (cnt_q == 8'd0) ? dec_log2 : dec_q;
        win_len     = 8'd1 << dec_eff;
        cnt_inc     = cnt_q + 8'd1;
        sum         = acc_q + ACC_W'(sample_data);
        win_done    = accept && (cnt_inc == win_len);
        start_frame = win_done && !busy_q;

        acc_d      = acc_q;
        cnt_d      = cnt_q;
        dec_d      = dec_eff;
        hold_d     = hold_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        ovr_d      = ovr_q;
        load_valid = 1'b0;
        load_data  = SYNC_BYTE;

        if (!enable) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (win_done) begin
            acc_d = '0;
            cnt_d = '0;
        end else if (accept) begin
            acc_d = sum;
            cnt_d = cnt_inc;
        end

        if (win_done && busy_q) begin
            ovr_d = 1'b1;
        end else if (overrun_clr) begin
            ovr_d = 1'b0;
        end

        if (start_frame) begin
            hold_d     = {1'b0, sum};
            load_valid = 1'b1;
            busy_d     = 1'b1;
            byte_idx_d = 2'd0;
        end else if (busy_q && load_ready) begin
            if (byte_idx_q == 2'd2) begin
                busy_d     = 1'b0;
                byte_idx_d = 2'd0;
            end else begin
                load_valid = 1'b1;
                load_data  = (byte_idx_q == 2'd0) ? hold_q[15:8] : hold_q[7:0];
                byte_idx_d = byte_idx_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            dec_q      <= '0;
            hold_q     <= '0;
            byte_idx_q <= '0;
            busy_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dec_q      <= dec_d;
            hold_q     <= hold_d;
            byte_idx_q <= byte_idx_d;
            busy_q     <= busy_d;
            ovr_q      <= ovr_d;
        end
    end

    fdc_uart_tx #(
        .CLK_DIV (CLK_DIV)
    ) u_tx (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .tx         (tx)
    );

    assign busy    = busy_q;
    assign overrun = ovr_q;

endmodule

// File: tb/tb_fdc_decim_uart.sv
// Directed bench for fdc_decim_uart at CLK_DIV=4: frame contents, timing, overrun and reset behaviour.
module tb_fdc_decim_uart;

    localparam int DIV   = 4;
    localparam int FRAME = 30 * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic       sample_valid = 1'b0;
    logic [7:0] sample_data = 8'd0;
    logic [2:0] dec_log2 = 3'd0;
    logic       overrun_clr = 1'b0;
    logic       tx, busy, overrun;

    int errors = 0;
    int checks = 0;

    fdc_decim_uart #(.CLK_DIV(DIV), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .dec_log2     (dec_log2),
        .overrun_clr  (overrun_clr),
        .tx           (tx),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; strobe is taken by the next rising edge.
    task automatic strobe(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge clk);
        sample_valid = 1'b0;
    endtask

    // Called at the negedge of frame cycle 0 (first start-bit cycle). Samples every bit at
    // mid-period, counts busy cycles over FRAME+1 cycles, and can inject one strobe at cycle inj.
    task automatic recv_frame(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                              input int inj, input logic [7:0] inj_d, input logic inj_clr);
        logic [29:0] fb;
        logic        framing;
        logic [7:0]  b;
        int          busy_n;
        fb      = '0;
        busy_n  = 0;
        for (int c = 0; c <= FRAME; c++) begin
            if (busy === 1'b1) busy_n++;
            if ((c % DIV) == DIV / 2) fb[c / DIV] = tx;
            sample_valid = (c == inj);
            sample_data  = inj_d;
            overrun_clr  = (c == inj) && inj_clr;
            @(negedge clk);
        end
        sample_valid = 1'b0;
        overrun_clr  = 1'b0;
        framing = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (fb[k*10] !== 1'b0 || fb[k*10+9] !== 1'b1) framing = 1'b0;
        end
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) b[i] = fb[k*10+1+i];
            case (k)
                0: check({tag, "_sync"}, 32'(b), 32'h0A5);
                1: check({tag, "_msb"},  32'(b), 32'(e1));
                default: check({tag, "_lsb"}, 32'(b), 32'(e2));
            endcase
        end
        check({tag, "_framing"}, 32'(framing), 32'd1);
        check({tag, "_busy_len"}, 32'(busy_n), 32'(FRAME));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst    = 1'b0;
        enable = 1'b1;
        @(negedge clk);

        // Basic 4-sample window: 10+20+30+40 = 100 = 0x0064
        dec_log2 = 3'd2;
        strobe(8'd10);
        strobe(8'd20);
        strobe(8'd30);
        check("basic_no_early_frame", 32'(busy), 32'd0);
        strobe(8'd40);
        check("basic_start_bit", 32'(tx), 32'd0);
        recv_frame("basic", 8'h00, 8'h64, -1, 8'h00, 1'b0);
        check("basic_overrun", 32'(overrun), 32'd0);

        // Single-sample window; start bit one cycle after the strobe
        dec_log2 = 3'd0;
        strobe(8'hFF);
        check("single_start_bit", 32'(tx), 32'd0);
        check("single_busy", 32'(busy), 32'd1);
        // Window completing in the cycle busy falls must start the next frame
        recv_frame("single", 8'h00, 8'hFF, FRAME, 8'h42, 1'b0);
        check("edge_start_bit", 32'(tx), 32'd0);
        check("edge_no_overrun", 32'(overrun), 32'd0);
        recv_frame("edge", 8'h00, 8'h42, -1, 8'h00, 1'b0);

        // Overrun: second window 10 cycles after the first is dropped
        strobe(8'h11);
        recv_frame("ovr", 8'h00, 8'h11, 9, 8'h22, 1'b0);
        check("ovr_set", 32'(overrun), 32'd1);
        repeat (DIV * 3) @(negedge clk);
        check("ovr_no_second_frame", 32'(busy), 32'd0);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Set wins over clear in the same cycle
        strobe(8'h01);
        recv_frame("setwin", 8'h00, 8'h01, 20, 8'h02, 1'b1);
        check("setwin_overrun", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;

        // Maximum window: 128 * 0xFF = 32640 = 0x7F80
        dec_log2 = 3'd7;
        for (int i = 0; i < 128; i++) strobe(8'hFF);
        check("max_start_bit", 32'(tx), 32'd0);
        recv_frame("max", 8'h7F, 8'h80, -1, 8'h00, 1'b0);
        check("max_overrun", 32'(overrun), 32'd0);

        // Mid-window dec_log2 change is ignored: 5+6 after 2 samples, then an 8-sample window
        dec_log2 = 3'd1;
        strobe(8'd5);
        dec_log2 = 3'd3;
        strobe(8'd6);
        check("mid_start_bit", 32'(tx), 32'd0);
        recv_frame("mid", 8'h00, 8'h0B, -1, 8'h00, 1'b0);
        for (int i = 0; i < 7; i++) strobe(8'd1);
        check("mid8_no_early_frame", 32'(busy), 32'd0);
        strobe(8'd1);
        check("mid8_start_bit", 32'(tx), 32'd0);
        recv_frame("mid8", 8'h00, 8'h08, -1, 8'h00, 1'b0);

        // enable=0 ignores samples
        dec_log2 = 3'd0;
        enable   = 1'b0;
        strobe(8'h55);
        check("disabled_no_frame", 32'(busy), 32'd0);
        enable = 1'b1;
        @(negedge clk);

        // Reset mid-frame aborts at once
        strobe(8'h3C);
        repeat (50) @(negedge clk);
        check("prerst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        strobe(8'h77);
        check("postrst_start_bit", 32'(tx), 32'd0);
        recv_frame("postrst", 8'h00, 8'h77, -1, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
